// File: rtl/al_accel_pkg.sv
// Shared types and constants for the accelerator's pooling path.
package al_accel_pkg;

  localparam int unsigned POOL_SEL_W    = 4;
  localparam int unsigned POOL_MAX_OUT  = 13;
  localparam int unsigned POOL_IN_W_MIN = 2;
  localparam int unsigned POOL_IN_W_MAX = 2 * POOL_MAX_OUT;

  typedef enum logic [2:0] {
    StIdle,
    StRowEven,
    StRowOdd,
    StDrain,
    StDone
  } pool_ctrl_state_t;

endpackage

// File: rtl/al_accel_pool_ctrl.sv
// Sequencer for 2x2 stride-2 max-pooling: steers buffer writes from a raster conv stream and
// drains the pooled row through a valid/ready output after every row pair.
module al_accel_pool_ctrl
  import al_accel_pkg::*;
#(
  parameter int unsigned IN_W = 26
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [5:0]            in_h,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [POOL_SEL_W-1:0] pool_sel_demux,
  output logic                  pool_mpbuf_ld_wrn,
  output logic                  pool_cp_enb,
  output logic                  pool_enb,
  output logic [POOL_SEL_W-1:0] pool_sel_mux,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned OUT_W = IN_W / 2;
  localparam logic [4:0] COL_LAST = 5'(IN_W - 1);
  localparam logic [POOL_SEL_W-1:0] IDX_LAST = POOL_SEL_W'(OUT_W - 1);

  pool_ctrl_state_t state_q, state_d;
  logic [4:0]            col_q, col_d;
  logic [5:0]            row_q, row_d;
  logic [5:0]            in_h_q, in_h_d;
  logic [POOL_SEL_W-1:0] idx_q, idx_d;
  logic [5:0]            row_next;
  logic [5:0]            in_h_even;

  // Odd heights are truncated by dropping bit 0.
  assign in_h_even = in_h & 6'b111110;
  assign row_next  = row_q + 6'd2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      in_h_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      in_h_q  <= in_h_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    in_h_d  = in_h_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          in_h_d  = in_h_even;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = (in_h_even == 6'd0) ? StDone : StRowEven;
        end
      end
      StRowEven: begin
        if (in_valid) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = StRowOdd;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      StRowOdd: begin
        if (in_valid) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            idx_d   = '0;
            state_d = StDrain;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            row_d   = row_next;
            state_d = (row_next == in_h_q) ? StDone : StRowEven;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Buffer controls are combinational so the write lands on the handshake edge.
  always_comb begin
    in_ready          = 1'b0;
    pool_sel_demux    = '0;
    pool_mpbuf_ld_wrn = 1'b0;
    pool_cp_enb       = 1'b0;
    pool_enb          = 1'b0;
    pool_sel_mux      = '0;
    out_valid         = 1'b0;
    out_last          = 1'b0;
    busy              = (state_q != StIdle);
    done              = (state_q == StDone);
    unique case (state_q)
      StRowEven: begin
        in_ready          = 1'b1;
        pool_enb          = in_valid;
        pool_sel_demux    = col_q[4:1];
        pool_mpbuf_ld_wrn = ~col_q[0];
        pool_cp_enb       = col_q[0];
      end
      StRowOdd: begin
        in_ready       = 1'b1;
        pool_enb       = in_valid;
        pool_sel_demux = col_q[4:1];
        pool_cp_enb    = 1'b1;
      end
      StDrain: begin
        out_valid    = 1'b1;
        pool_sel_mux = idx_q;
        out_last     = (idx_q == IDX_LAST);
      end
      default: ;
    endcase
  end

endmodule
